addsub4_seq: RTL and testbench

ADDSUB4_SEQ -- requirements
Module: addsub4_seq

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub4_stage.sv | 19 +
 rtl/rise_detect.sv | 19 +
 rtl/addsub4_seq.sv | 120 ++++++++++++
 tb/tb_addsub4_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared width constant and controller state encoding for the sequential add/sub front end.
package addsub_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

endpackage

// File: rtl/addsub4_stage.sv
// Combinational add/sub stage: s = a + b (cin=0) or a - b via a + ~b + 1 (cin=1).
module addsub4_stage #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] s_o,
    output logic         cout_o
);

    logic [W-1:0] w_b_eff;
    logic [W:0]   w_sum;

    assign w_b_eff = cin_i ? ~b_i : b_i;
    assign w_sum   = {1'b0, a_i} + {1'b0, w_b_eff} + {{W{1'b0}}, cin_i};
    assign {cout_o, s_o} = w_sum;

endmodule

// File: rtl/rise_detect.sv
// Single-cycle pulse on the rising edge of an already-synchronised level.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_o
);

    logic r_prev;

    // NOTE: history resets to 1 so a level already high when reset lifts is not seen as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) r_prev <= 1'b1;
        else        r_prev <= level_i;
    end

    assign pulse_o = level_i & ~r_prev;

endmodule

// File: rtl/addsub4_seq.sv
// Button-driven operand sequencer: latches A, then B/op, exercises an external add/sub stage and shows the result with flags.
module addsub4_seq #(
    parameter int W = addsub_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_i,
    input  logic         op_i,
    input  logic         enter_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    output logic         cin_o,
    input  logic [W-1:0] s_i,
    input  logic         cout_i,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         ovf_o,
    output logic         zero_o,
    output logic         neg_o,
    output logic         done_o,
    output logic         busy_o,
    output logic [1:0]   state_o,
    output logic [3:0]   op_count_o
);

    addsub_pkg::state_t r_state, w_next;

    logic         w_enter_evt;
    logic         w_load_a, w_load_b, w_capture;
    logic         w_ovf;
    logic [W-1:0] r_a, r_b, r_result;
    logic         r_cin, r_carry, r_ovf, r_zero, r_neg, r_done;
    logic [3:0]   r_op_count;

    rise_detect u_enter (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (enter_i),
        .pulse_o (w_enter_evt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= addsub_pkg::S_A;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load_a  = 1'b0;
        w_load_b  = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            addsub_pkg::S_A, addsub_pkg::S_SHOW: begin
                if (w_enter_evt) begin
                    w_load_a = 1'b1;
                    w_next   = addsub_pkg::S_B;
                end
            end
            addsub_pkg::S_B: begin
                if (w_enter_evt) begin
                    w_load_b = 1'b1;
                    w_next   = addsub_pkg::S_EXEC;
                end
            end
            addsub_pkg::S_EXEC: begin
                w_capture = 1'b1;
                w_next    = addsub_pkg::S_SHOW;
            end
            default: w_next = addsub_pkg::S_A;
        endcase
    end

    // Signed overflow judged on the operands as presented to the stage.
    assign w_ovf = r_cin ? ((r_a[W-1] != r_b[W-1]) && (s_i[W-1] != r_a[W-1]))
                         : ((r_a[W-1] == r_b[W-1]) && (s_i[W-1] != r_a[W-1]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_done     <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_done <= w_capture;
            if (w_load_a) r_a <= data_i;
            if (w_load_b) begin
                r_b   <= data_i;
                r_cin <= op_i;
            end
            if (w_capture) begin
                r_result   <= s_i;
                r_carry    <= cout_i;
                r_ovf      <= w_ovf;
                r_zero     <= (s_i == '0);
                r_neg      <= s_i[W-1];
                r_op_count <= r_op_count + 4'd1;
            end
        end
    end

    assign a_o        = r_a;
    assign b_o        = r_b;
    assign cin_o      = r_cin;
    assign result_o   = r_result;
    assign carry_o    = r_carry;
    assign ovf_o      = r_ovf;
    assign zero_o     = r_zero;
    assign neg_o      = r_neg;
    assign done_o     = r_done;
    assign busy_o     = (r_state == addsub_pkg::S_B) || (r_state == addsub_pkg::S_EXEC);
    assign state_o    = r_state;
    assign op_count_o = r_op_count;

endmodule

// File: tb/tb_addsub4_seq.sv
// Self-checking bench: directed vector table, randomized ops against an arithmetic model, reset and button corner cases.
module tb_addsub4_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data_i;
    logic         op_i;
    logic         enter_i;
    logic [W-1:0] a_o, b_o, s_w, result_o;
    logic         cin_o, cout_w, carry_o, ovf_o, zero_o, neg_o, done_o, busy_o;
    logic [1:0]   state_o;
    logic [3:0]   op_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       op;
        logic [3:0] res;
        logic       carry;
        logic       ovf;
        logic       zero;
        logic       neg;
    } vec_t;

    always #5 clk = ~clk;

    addsub4_seq #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .op_i       (op_i),
        .enter_i    (enter_i),
        .a_o        (a_o),
        .b_o        (b_o),
        .cin_o      (cin_o),
        .s_i        (s_w),
        .cout_i     (cout_w),
        .result_o   (result_o),
        .carry_o    (carry_o),
        .ovf_o      (ovf_o),
        .zero_o     (zero_o),
        .neg_o      (neg_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .state_o    (state_o),
        .op_count_o (op_count_o)
    );

    addsub4_stage #(.W(W)) u_stage (
        .a_i    (a_o),
        .b_i    (b_o),
        .cin_i  (cin_o),
        .s_o    (s_w),
        .cout_o (cout_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference from plain integer arithmetic on the unsigned and two's-complement views.
    function automatic vec_t model(input logic [3:0] a, input logic [3:0] b, input logic op);
        vec_t v;
        int ua, ub, sa, sb, sr, ur;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        sr = op ? sa - sb : sa + sb;
        ur = op ? (ua - ub + 16) % 16 : (ua + ub) % 16;
        v.a     = a;
        v.b     = b;
        v.op    = op;
        v.res   = 4'(ur);
        v.carry = op ? (ua >= ub) : (ua + ub > 15);
        v.ovf   = (sr < -8) || (sr > 7);
        v.zero  = (ur == 0);
        v.neg   = (ur >= 8);
        return v;
    endfunction

    task automatic do_reset(input logic en);
        rst_n   = 1'b0;
        enter_i = en;
        data_i  = '0;
        op_i    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_count = 0;
    endtask

    task automatic press_a(input logic [3:0] a);
        data_i  = a;
        enter_i = 1'b1;
        tick();
        enter_i = 1'b0;
        check("a_state", 32'(state_o), 32'(1));
        check("a_latch", 32'(a_o), 32'(a));
        check("a_busy", 32'(busy_o), 32'(1));
        tick();
    endtask

    task automatic finish_b(input vec_t v, input string name);
        data_i  = v.b;
        op_i    = v.op;
        enter_i = 1'b1;
        tick();
        enter_i = 1'b0;
        check({name, "_exec_state"}, 32'(state_o), 32'(2));
        check({name, "_b"}, 32'(b_o), 32'(v.b));
        check({name, "_cin"}, 32'(cin_o), 32'(v.op));
        check({name, "_exec_done"}, 32'(done_o), 32'(0));
        op_i   = ~v.op;
        data_i = ~v.b;
        tick();
        exp_count = (exp_count + 1) % 16;
        check({name, "_show_state"}, 32'(state_o), 32'(3));
        check({name, "_done"}, 32'(done_o), 32'(1));
        check({name, "_result"}, 32'(result_o), 32'(v.res));
        check({name, "_carry"}, 32'(carry_o), 32'(v.carry));
        check({name, "_ovf"}, 32'(ovf_o), 32'(v.ovf));
        check({name, "_zero"}, 32'(zero_o), 32'(v.zero));
        check({name, "_neg"}, 32'(neg_o), 32'(v.neg));
        check({name, "_count"}, 32'(op_count_o), 32'(exp_count));
        check({name, "_busy"}, 32'(busy_o), 32'(0));
        tick();
        check({name, "_done_low"}, 32'(done_o), 32'(0));
        check({name, "_held"}, 32'(result_o), 32'(v.res));
    endtask

    task automatic run_op(input vec_t v, input string name);
        press_a(v.a);
        finish_b(v, name);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;

        tbl[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0};

        do_reset(1'b0);
        check("rst_state", 32'(state_o), 32'(0));
        check("rst_a", 32'(a_o), 32'(0));
        check("rst_b", 32'(b_o), 32'(0));
        check("rst_result", 32'(result_o), 32'(0));
        check("rst_flags", 32'({cin_o, carry_o, ovf_o, zero_o, neg_o, done_o, busy_o}), 32'(0));
        check("rst_count", 32'(op_count_o), 32'(0));

        for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            v = model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Button held through reset release must not register until re-pressed.
        do_reset(1'b1);
        data_i = 4'hA;
        repeat (3) tick();
        check("hold_rst_state", 32'(state_o), 32'(0));
        check("hold_rst_a", 32'(a_o), 32'(0));
        enter_i = 1'b0;
        tick();
        press_a(4'hA);

        // Reset mid S_B abandons the operation.
        do_reset(1'b0);
        press_a(4'h6);
        rst_n = 1'b0;
        tick();
        check("rstb_state", 32'(state_o), 32'(0));
        check("rstb_a", 32'(a_o), 32'(0));
        check("rstb_done", 32'(done_o), 32'(0));
        check("rstb_count", 32'(op_count_o), 32'(0));
        rst_n = 1'b1;
        tick();

        // Reset during S_EXEC: no capture, no pulse.
        run_op(model(4'h2, 4'h2, 1'b0), "pre_exec");
        press_a(4'h6);
        data_i  = 4'h1;
        enter_i = 1'b1;
        tick();
        enter_i = 1'b0;
        check("rste_in_exec", 32'(state_o), 32'(2));
        rst_n = 1'b0;
        tick();
        check("rste_state", 32'(state_o), 32'(0));
        check("rste_done", 32'(done_o), 32'(0));
        check("rste_result", 32'(result_o), 32'(0));
        check("rste_count", 32'(op_count_o), 32'(0));
        rst_n = 1'b1;
        tick();
        tick();
        check("rste_after_done", 32'(done_o), 32'(0));
        exp_count = 0;

        // Sixteen captures wrap the counter back to zero.
        for (int i = 0; i < 16; i++) begin
            v = model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run_op(v, $sformatf("wrap%0d", i));
        end
        check("wrap_count", 32'(op_count_o), 32'(0));

        // Enter held five cycles from S_SHOW latches A exactly once.
        data_i  = 4'h9;
        enter_i = 1'b1;
        tick();
        check("held_state", 32'(state_o), 32'(1));
        check("held_a", 32'(a_o), 32'(9));
        data_i = 4'h4;
        repeat (4) tick();
        check("held_state2", 32'(state_o), 32'(1));
        check("held_a2", 32'(a_o), 32'(9));
        check("held_old_result", 32'(result_o), 32'(v.res));
        enter_i = 1'b0;
        tick();
        finish_b(model(4'h9, 4'h2, 1'b0), "held_op");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
